if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_pkg.sv | 16 +
 rtl/if_fetch_unit_timeout.sv | 37 +++
 rtl/if_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
//   ADDRESS_LEN    : default width of PC, memory address and instruction word
//   FETCH_PC_STEP  : byte increment between sequential instructions
//   fetch_state_t  : 2-bit encoding of the fetch controller states
package if_fetch_unit_pkg;

    localparam int ADDRESS_LEN   = 32;
    localparam int FETCH_PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH_ST_FETCH   = 2'd0,
        FETCH_ST_HAVE    = 2'd1,
        FETCH_ST_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_timeout.sv
// fetch_timeout_counter: watchdog for an outstanding instruction request.
// Built only when FETCH_TIMEOUT_EN is defined in the including build.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : restart the count (a new request is being issued)
//   en   : one more cycle of waiting without an acknowledge
//   hit  : count has reached LIMIT (held there until clr/rst)
module fetch_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] cnt;

    // Saturates at LIMIT so a very long stall cannot wrap and re-arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == LIMIT_C);

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF pipeline register.
// Owns the PC, issues requests over a variable-latency req/ack handshake,
// buffers one returned instruction with its PC+4, and handles branch
// redirects, downstream freeze and dropping of stale responses.
// Optional build macro: FETCH_TIMEOUT_EN enables the request watchdog that
// drives fetch_error; without it fetch_error is tied low.
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   freeze           : hazard stall, holds the buffered instruction
//   branch_taken     : redirect request from EXE, target on branch_addr
//   mem_req/mem_addr : instruction memory request and its address
//   mem_ack          : one-cycle pulse, mem_rdata valid in that cycle
//   mem_rdata        : returned instruction word
//   fetch_valid      : pc_out/instruction_out hold a valid instruction
//   pc_out           : address of buffered instruction + 4 (0 when invalid)
//   instruction_out  : buffered instruction (0 when invalid)
//   fetch_error      : sticky watchdog error
//
// state    | meaning
// ---------+--------------------------------------------------------
// FETCH    | request for pc_reg outstanding
// HAVE     | buffer holds a valid instruction, no request
// DISCARD  | redirected mid-request; waiting to drop the stale ack
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W         = ADDRESS_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] instruction_out,
    output logic              fetch_error
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(FETCH_PC_STEP);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] stale_addr, stale_next;
    logic [ADDR_W-1:0] buf_pc, buf_ins;
    logic              buf_ld, buf_clr;
    logic              req_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH_ST_FETCH;
            pc_reg     <= RESET_PC;
            stale_addr <= '0;
            buf_pc     <= '0;
            buf_ins    <= '0;
        end else begin
            state      <= state_next;
            pc_reg     <= pc_next;
            stale_addr <= stale_next;
            if (buf_clr) begin
                buf_pc  <= '0;
                buf_ins <= '0;
            end else if (buf_ld) begin
                buf_pc  <= pc_reg + PC_STEP;
                buf_ins <= mem_rdata;
            end
        end
    end

    // req_start flags every edge after which a fresh request is presented,
    // including FETCH->FETCH when an ack coincides with a redirect.
    always_comb begin
        state_next = state;
        pc_next    = pc_reg;
        stale_next = stale_addr;
        buf_ld     = 1'b0;
        buf_clr    = 1'b0;
        req_start  = 1'b0;
        case (state)
            FETCH_ST_FETCH: begin
                if (mem_ack && branch_taken) begin
                    pc_next   = branch_addr;
                    req_start = 1'b1;
                end else if (mem_ack) begin
                    buf_ld     = 1'b1;
                    state_next = FETCH_ST_HAVE;
                end else if (branch_taken) begin
                    // Memory is still working on pc_reg; keep presenting it
                    // until the ack so the handshake stays consistent.
                    pc_next    = branch_addr;
                    stale_next = pc_reg;
                    state_next = FETCH_ST_DISCARD;
                    req_start  = 1'b1;
                end
            end
            FETCH_ST_DISCARD: begin
                if (branch_taken) begin
                    pc_next = branch_addr;
                end
                if (mem_ack) begin
                    state_next = FETCH_ST_FETCH;
                    req_start  = 1'b1;
                end
            end
            FETCH_ST_HAVE: begin
                if (branch_taken) begin
                    buf_clr    = 1'b1;
                    pc_next    = branch_addr;
                    state_next = FETCH_ST_FETCH;
                    req_start  = 1'b1;
                end else if (!freeze) begin
                    buf_clr    = 1'b1;
                    pc_next    = pc_reg + PC_STEP;
                    state_next = FETCH_ST_FETCH;
                    req_start  = 1'b1;
                end
            end
            default: begin
                state_next = FETCH_ST_FETCH;
            end
        endcase
    end

    assign mem_req         = (state == FETCH_ST_FETCH) || (state == FETCH_ST_DISCARD);
    assign mem_addr        = (state == FETCH_ST_DISCARD) ? stale_addr : pc_reg;
    assign fetch_valid     = (state == FETCH_ST_HAVE);
    assign pc_out          = fetch_valid ? buf_pc  : '0;
    assign instruction_out = fetch_valid ? buf_ins : '0;

`ifdef FETCH_TIMEOUT_EN
    logic to_hit;
    logic err_q;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (req_start),
        .en  (mem_req && !mem_ack),
        .hit (to_hit)
    );

    // Error only flags the condition; the request keeps running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_error = err_q;
`else
    assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        fetch_valid;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_error;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W         (32),
        .RESET_PC       (32'h0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .fetch_valid     (fetch_valid),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_error     (fetch_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        sb[$];
    int          lat = 1;
    int          req_cnt = 0;
    logic [31:0] req_addr = '0;
    logic [31:0] exp_next = '0;
    bit          stale = 1'b0;
    int          br_mode = 0;      // 0 none, 1 at request cycle br_cnt, 2 at ack, 3 while valid
    int          br_cnt = 0;
    logic [31:0] br_tgt = '0;
    bit          frz = 1'b0;
    bit          spurious = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE3A0_0000 + (a >> 2) + 32'd1;
    endfunction

    task automatic tick();
        bit ack;
        bit br;
        bit exp_valid;
        int cur_cnt;
        @(negedge clk);
        exp_valid = (sb.size() > 0);
        check_val("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
        check_val("mem_req", {31'b0, mem_req}, {31'b0, !exp_valid});
        if (exp_valid) begin
            check_val("pc_out", pc_out, sb[0].pc);
            check_val("instruction_out", instruction_out, sb[0].ins);
        end else begin
            check_val("pc_out_idle", pc_out, 32'h0);
            check_val("instr_idle", instruction_out, 32'h0);
        end
`ifndef FETCH_TIMEOUT_EN
        check_val("fetch_error_off", {31'b0, fetch_error}, 32'h0);
`endif
        if (mem_req) begin
            if (req_cnt == 0) begin
                check_val("req_addr", mem_addr, exp_next);
                req_addr = mem_addr;
            end else begin
                check_val("req_stable", mem_addr, req_addr);
            end
        end

        ack = 1'b0;
        br = 1'b0;
        cur_cnt = req_cnt;
        if (mem_req) begin
            if (req_cnt >= lat) begin
                ack = 1'b1;
                req_cnt = 0;
            end else begin
                req_cnt++;
            end
        end else begin
            req_cnt = 0;
        end

        case (br_mode)
            1: br = mem_req && !ack && (cur_cnt == br_cnt);
            2: br = ack;
            3: br = exp_valid;
            default: br = 1'b0;
        endcase
        if (br) br_mode = 0;

        if (exp_valid && (br || !frz)) void'(sb.pop_front());
        if (ack) begin
            if (!stale && !br) begin
                sb.push_back('{pc: mem_addr + 32'd4, ins: mem_word(mem_addr)});
                exp_next = mem_addr + 32'd4;
            end
            stale = 1'b0;
        end
        if (br) begin
            exp_next = br_tgt;
            if (mem_req && !ack) stale = 1'b1;
        end

        mem_ack = ack;
        mem_rdata = ack ? mem_word(mem_addr) : 32'h0;
        if (spurious && exp_valid && !mem_req) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end
        branch_taken = br;
        branch_addr = br ? br_tgt : 32'h0;
        freeze = frz;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        mem_ack = 1'b0;
        branch_taken = 1'b0;
        freeze = 1'b0;
        #1;
        check_val("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check_val("rst_mem_req", {31'b0, mem_req}, 32'h1);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_pc_out", pc_out, 32'h0);
        check_val("rst_fetch_error", {31'b0, fetch_error}, 32'h0);
        sb.delete();
        req_cnt = 0;
        stale = 1'b0;
        exp_next = 32'h0;
        br_mode = 0;
        frz = 1'b0;
        spurious = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // sequential fetch, one-cycle memory
        lat = 1;
        repeat (8) tick();

        // freeze while holding an instruction
        frz = 1'b1;
        repeat (5) tick();
        frz = 1'b0;
        repeat (6) tick();

        // redirect on cycle 2 of a 5-cycle request: stale data dropped
        lat = 5; br_mode = 1; br_cnt = 2; br_tgt = 32'h100;
        repeat (14) tick();

        // redirect coincident with ack
        lat = 2; br_mode = 2; br_tgt = 32'h40;
        repeat (8) tick();

        // redirect together with freeze while holding
        lat = 1; frz = 1'b1; br_mode = 3; br_tgt = 32'h80;
        repeat (6) tick();
        frz = 1'b0;
        repeat (4) tick();

        // acks while no request is outstanding are ignored
        spurious = 1'b1; frz = 1'b1;
        repeat (6) tick();
        spurious = 1'b0; frz = 1'b0;
        repeat (4) tick();

        // zero-latency memory
        lat = 0;
        repeat (6) tick();

        // PC wrap at top of address space
        lat = 1; br_mode = 3; br_tgt = 32'hFFFF_FFFC;
        repeat (10) tick();

        // several redirects during one stale request: last one wins
        lat = 6; br_mode = 1; br_cnt = 1; br_tgt = 32'h200;
        repeat (2) tick();
        br_mode = 1; br_cnt = 3; br_tgt = 32'h300;
        repeat (14) tick();

        // reset in the middle of a request
        lat = 5;
        repeat (3) tick();
        do_reset();
        lat = 1;
        repeat (6) tick();

`ifdef FETCH_TIMEOUT_EN
        lat = 1000;
        repeat (12) tick();
        check_val("timeout_set", {31'b0, fetch_error}, 32'h1);
        lat = 0;
        repeat (3) tick();
        check_val("timeout_sticky", {31'b0, fetch_error}, 32'h1);
        do_reset();
        check_val("timeout_cleared", {31'b0, fetch_error}, 32'h0);
        lat = 1;
        repeat (4) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
